vga_bitmap_scaler: RTL and testbench
====================================

// Module: vga_bitmap_scaler
// PURPOSE
// Parametrised VGA timing generator plus scaled monochrome bitmap renderer. Produces hsync/vsync
// and 12-bit RGB for a BMP_W x BMP_H bitmap, magnified by SCALE and placed at (WIN_X, WIN_Y).
// Bitmap is captured once per frame into a shadow register (tear-free); fg/bg colours selectable.
// Sits between the video memory read port and the board VGA DAC pins.
// PARAMETERS
// H_ACTIVE 640 visible pixels/line;  H_FP 16 front porch;  H_SYNC 96 pulse;  H_BP 48 back porch
// V_ACTIVE 480 visible lines;  V_FP 10 front porch;  V_SYNC 2 pulse;  V_BP 33 back porch
// BMP_W 8 bitmap columns;  BMP_H 8 bitmap rows;  SCALE 8 screen pixels per bitmap pixel (>=1)
// WIN_X 288 first window column;  WIN_Y 208 first window line (window must fit inside active area)
// PORTS
// dclk         in   1            pixel clock (25 MHz at defaults)
// clr_n        in   1            synchronous reset, active low
// vdata        in   BMP_W*BMP_H  bitmap, bit r*BMP_W+c = row r, col c; bit 0 top-left
// fg_color     in   12           {R,G,B} 4b each for bitmap bit 1
// bg_color     in   12           {R,G,B} for bitmap bit 0 inside window
// hsync        out  1            horizontal sync, active low
// vsync        out  1            vertical sync, active low
// red/green/blue out 4 each      colour outputs, registered
// frame_start  out  1            one-cycle pulse, first pixel of each frame at outputs
// BEHAVIOUR
// - H_TOT=H_ACTIVE+H_FP+H_SYNC+H_BP (800), V_TOT likewise (525); counter widths $clog2 of totals.
// - Line order: active, front porch, sync, back porch. hc 0..H_TOT-1, wraps to 0 and advances vc;
//   vc 0..V_TOT-1 wraps to 0 when hc wraps at vc=V_TOT-1.
// - Raw sync: hsync low iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751); vsync same on vc (490..491).
// - Window: WIN_X <= hc < WIN_X+BMP_W*SCALE and WIN_Y <= vc < WIN_Y+BMP_H*SCALE (inclusive start, exclusive end).
// - Column/row index from sub-pixel counters (count 0..SCALE-1, step index on wrap); no dividers.
//   Counters clear at window entry / line start; row counters clear at frame start.
// - Shadow: vdata copied to shadow reg on cycle hc=H_TOT-1, vc=V_TOT-1; otherwise held. vdata
//   changes mid-frame never visible before the next frame.
// - Pipeline, 2 cycles: stage 1 registers window flag, active flag, bit index, raw syncs;
//   stage 2 selects shadow bit, drives RGB/hsync/vsync. Counters (hc,vc) at cycle t -> outputs at t+2,
//   syncs delayed identically so colour/sync stay aligned.
// - Colour: in window -> bit?fg_color:bg_color; active but outside window -> 0; blanking -> 0.
// - frame_start high exactly one cycle, same cycle outputs show (hc,vc)=(0,0); once per frame.
// - Reset (clr_n=0 at dclk edge, any time incl. mid-line): hc=vc=0, sub-counters=0, shadow=0,
//   pipeline flushed; outputs hsync=1, vsync=1, RGB=0, frame_start=0 from the following cycle.
//   First frame after reset shows bg_color over whole window (shadow=0).
// - Fg/bg sampled in stage 2 (no frame latching); colour inputs may change any cycle.
// TESTING
// 1 Hold clr_n=0 5 cycles -> hsync=vsync=1, RGB=0, frame_start=0; release -> frame_start at cycle 2.
// 2 Free-run 2 frames -> hsync low 96 cycles per 800, vsync low 1600 cycles per 420000; frame_start period 420000.
// 3 vdata=64'h1, fg=12'hFFF, bg=12'h00F, frame 2 -> lines 208..215 cols 288..295 white, 296..351 blue, 287 and 352 black.
// 4 vdata=64'h8000_0000_0000_0000 -> only cols 344..351 lines 264..271 fg; line 272 black.
// 5 Change vdata mid-frame (line 300) -> current frame unchanged, new image from next frame_start.
// 6 Assert clr_n=0 one cycle at hc=400,vc=250 -> next frame_start exactly 2 cycles after release, timing intact.

Source files
------------

// File: rtl/vga_bitmap_scaler.sv
// VGA timing generator with a scaled monochrome bitmap window.
// The bitmap is shadowed once per frame so that mid-frame writes never tear the image.
module vga_bitmap_scaler #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BMP_W    = 8,
  parameter int BMP_H    = 8,
  parameter int SCALE    = 8,
  parameter int WIN_X    = 288,
  parameter int WIN_Y    = 208
) (
  input  logic                     dclk,
  input  logic                     clr_n,
  input  logic [BMP_W*BMP_H-1:0]   vdata,
  input  logic [11:0]              fg_color,
  input  logic [11:0]              bg_color,
  output logic                     hsync,
  output logic                     vsync,
  output logic [3:0]               red,
  output logic [3:0]               green,
  output logic [3:0]               blue,
  output logic                     frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);
  localparam int NPIX  = BMP_W * BMP_H;
  localparam int IW    = (NPIX > 1)  ? $clog2(NPIX)  : 1;
  localparam int CW    = (BMP_W > 1) ? $clog2(BMP_W) : 1;
  localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_ACT_E  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_E  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_S     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_E     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_S     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_E     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] WX_S     = HW'(WIN_X);
  localparam logic [HW-1:0] WX_E     = HW'(WIN_X + BMP_W * SCALE);
  localparam logic [VW-1:0] WY_S     = VW'(WIN_Y);
  localparam logic [VW-1:0] WY_E     = VW'(WIN_Y + BMP_H * SCALE);
  localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
  localparam logic [IW-1:0] ROW_STEP = IW'(BMP_W);

  logic [HW-1:0]   hc;
  logic [VW-1:0]   vc;
  logic            line_end;
  logic            frame_end;
  logic            in_h;
  logic            in_v;

  logic [SW-1:0]   sx;
  logic [CW-1:0]   col;
  logic [SW-1:0]   sy;
  logic [IW-1:0]   row_base;
  logic [IW-1:0]   idx;

  logic [NPIX-1:0] shadow;

  logic            s1_win;
  logic            s1_act;
  logic [IW-1:0]   s1_idx;
  logic            s1_hs;
  logic            s1_vs;
  logic            s1_first;

  logic [11:0]     pix_color;

  assign line_end  = (hc == H_LAST);
  assign frame_end = line_end && (vc == V_LAST);
  assign in_h      = (hc >= WX_S) && (hc < WX_E);
  assign in_v      = (vc >= WY_S) && (vc < WY_E);
  assign idx       = row_base + IW'(col);

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      hc <= '0;
      vc <= '0;
    end else if (line_end) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Column position: cleared whenever outside the window so it starts at 0 on entry.
  always_ff @(posedge dclk) begin
    if (!clr_n || !in_h) begin
      sx  <= '0;
      col <= '0;
    end else if (sx == S_LAST) begin
      sx  <= '0;
      col <= col + 1'b1;
    end else begin
      sx  <= sx + 1'b1;
    end
  end

  // Row position tracked as a base bit index so no multiplier is needed.
  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      sy       <= '0;
      row_base <= '0;
    end else if (line_end) begin
      if (!in_v) begin
        sy       <= '0;
        row_base <= '0;
      end else if (sy == S_LAST) begin
        sy       <= '0;
        row_base <= row_base + ROW_STEP;
      end else begin
        sy       <= sy + 1'b1;
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      shadow <= '0;
    end else if (frame_end) begin
      shadow <= vdata;
    end
  end

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      s1_win   <= 1'b0;
      s1_act   <= 1'b0;
      s1_idx   <= '0;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_first <= 1'b0;
    end else begin
      s1_win   <= in_h && in_v;
      s1_act   <= (hc < H_ACT_E) && (vc < V_ACT_E);
      s1_idx   <= idx;
      s1_hs    <= !((hc >= HS_S) && (hc < HS_E));
      s1_vs    <= !((vc >= VS_S) && (vc < VS_E));
      s1_first <= (hc == '0) && (vc == '0);
    end
  end

  always_comb begin
    pix_color = 12'h000;
    if (s1_act && s1_win) begin
      pix_color = shadow[s1_idx] ? fg_color : bg_color;
    end
  end

  always_ff @(posedge dclk) begin
    if (!clr_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= 4'h0;
      green       <= 4'h0;
      blue        <= 4'h0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= s1_hs;
      vsync       <= s1_vs;
      red         <= pix_color[11:8];
      green       <= pix_color[7:4];
      blue        <= pix_color[3:0];
      frame_start <= s1_first;
    end
  end

endmodule

// File: tb/tb_vga_bitmap_scaler.sv
// Scoreboard bench for vga_bitmap_scaler using a reduced timing so several frames run quickly.
// Expected pixels come from a divide-based reference model queued two cycles ahead of the outputs.
module tb_vga_bitmap_scaler;

  localparam int H_ACTIVE = 40;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 6;
  localparam int H_BP     = 6;
  localparam int V_ACTIVE = 30;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 3;
  localparam int BMP_W    = 8;
  localparam int BMP_H    = 8;
  localparam int SCALE    = 2;
  localparam int WIN_X    = 10;
  localparam int WIN_Y    = 8;
  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOT * V_TOT;

  typedef struct packed {
    logic hs;
    logic vs;
    logic fs;
    logic win;
    logic pix;
    int   hc;
    int   vc;
  } exp_t;

  logic        dclk = 1'b0;
  logic        clr_n = 1'b0;
  logic [63:0] vdata = 64'h0;
  logic [11:0] fg_color = 12'h000;
  logic [11:0] bg_color = 12'h000;
  logic        hsync;
  logic        vsync;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        frame_start;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          m_hc = 0;
  int          m_vc = 0;
  logic [63:0] m_shadow = 64'h0;
  int          hs_low = 0;
  int          vs_low = 0;
  int          fs_cnt = 0;
  int          n;

  vga_bitmap_scaler #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BMP_W(BMP_W), .BMP_H(BMP_H), .SCALE(SCALE), .WIN_X(WIN_X), .WIN_Y(WIN_Y)
  ) dut (
    .dclk(dclk),
    .clr_n(clr_n),
    .vdata(vdata),
    .fg_color(fg_color),
    .bg_color(bg_color),
    .hsync(hsync),
    .vsync(vsync),
    .red(red),
    .green(green),
    .blue(blue),
    .frame_start(frame_start)
  );

  always #5 dclk = ~dclk;

  function automatic exp_t idleEntry();
    exp_t e;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    e.hc = -1;
    e.vc = -1;
    return e;
  endfunction

  // Models the cycle whose rising edge comes next, using the inputs driven right now.
  task automatic applyStimulus();
    exp_t e;
    if (clr_n == 1'b0) begin
      sb.delete();
      sb.push_back(idleEntry());
      sb.push_back(idleEntry());
      m_hc = 0;
      m_vc = 0;
      m_shadow = 64'h0;
    end else begin
      e.hc  = m_hc;
      e.vc  = m_vc;
      e.hs  = !(m_hc >= H_ACTIVE + H_FP && m_hc < H_ACTIVE + H_FP + H_SYNC);
      e.vs  = !(m_vc >= V_ACTIVE + V_FP && m_vc < V_ACTIVE + V_FP + V_SYNC);
      e.fs  = (m_hc == 0) && (m_vc == 0);
      e.win = (m_hc >= WIN_X) && (m_hc < WIN_X + BMP_W * SCALE) &&
              (m_vc >= WIN_Y) && (m_vc < WIN_Y + BMP_H * SCALE);
      e.pix = e.win ? m_shadow[((m_vc - WIN_Y) / SCALE) * BMP_W + (m_hc - WIN_X) / SCALE] : 1'b0;
      sb.push_back(e);
      if (m_hc == H_TOT - 1 && m_vc == V_TOT - 1) m_shadow = vdata;
      if (m_hc == H_TOT - 1) begin
        m_hc = 0;
        m_vc = (m_vc == V_TOT - 1) ? 0 : m_vc + 1;
      end else begin
        m_hc = m_hc + 1;
      end
    end
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [11:0] exp_rgb;
    logic [11:0] got_rgb;
    if (hsync === 1'b0) hs_low++;
    if (vsync === 1'b0) vs_low++;
    if (frame_start === 1'b1) fs_cnt++;
    if (sb.size() == 0) return;
    e = sb.pop_front();
    exp_rgb = e.win ? (e.pix ? fg_color : bg_color) : 12'h000;
    got_rgb = {red, green, blue};
    checks++;
    assert ({hsync, vsync, frame_start, got_rgb} === {e.hs, e.vs, e.fs, exp_rgb}) else begin
      errors++;
      $error("[TB] FAIL pixel(%0d,%0d) observed hs=%b vs=%b fs=%b rgb=%h expected hs=%b vs=%b fs=%b rgb=%h",
             e.hc, e.vc, hsync, vsync, frame_start, got_rgb, e.hs, e.vs, e.fs, exp_rgb);
    end
  endtask

  task automatic runCycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      applyStimulus();
      @(negedge dclk);
      checkOutput();
    end
  endtask

  task automatic checkValue(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitFrameStart(input int limit, output int cycles);
    cycles = 0;
    do begin
      runCycles(1);
      cycles++;
    end while (frame_start !== 1'b1 && cycles < limit);
  endtask

  task automatic runTo(input int hc, input int vc);
    int guard;
    guard = 0;
    while (!(m_hc == hc && m_vc == vc) && guard < FRAME + 10) begin
      runCycles(1);
      guard++;
    end
    checkValue("reach_position", (m_hc == hc && m_vc == vc) ? 1 : 0, 1);
  endtask

  task automatic checkFramePeriod(input string tag);
    hs_low = 0;
    vs_low = 0;
    fs_cnt = 0;
    runCycles(FRAME);
    checkValue({tag, "_fs_at_period"}, int'(frame_start === 1'b1), 1);
    checkValue({tag, "_fs_count"}, fs_cnt, 1);
    checkValue({tag, "_hsync_low"}, hs_low, H_SYNC * V_TOT);
    checkValue({tag, "_vsync_low"}, vs_low, V_SYNC * H_TOT);
  endtask

  initial begin
    clr_n    = 1'b0;
    vdata    = 64'h1;
    fg_color = 12'hFFF;
    bg_color = 12'h00F;
    @(negedge dclk);

    $display("[TB] reset hold");
    runCycles(5);
    checkValue("reset_hsync", int'(hsync), 1);
    checkValue("reset_vsync", int'(vsync), 1);
    checkValue("reset_rgb", int'({red, green, blue}), 0);
    checkValue("reset_frame_start", int'(frame_start), 0);

    clr_n = 1'b1;
    waitFrameStart(10, n);
    checkValue("release_latency", n, 2);

    $display("[TB] free-run timing, first frame shows background window");
    checkFramePeriod("frame1");
    $display("[TB] top-left bit set");
    checkFramePeriod("frame2");

    $display("[TB] bottom-right bit set");
    vdata = 64'h8000_0000_0000_0000;
    runCycles(FRAME);
    runCycles(FRAME);

    $display("[TB] mid-frame bitmap and colour change");
    runTo(0, 15);
    vdata    = 64'h00FF_0000_0000_FF81;
    fg_color = 12'hA5C;
    bg_color = 12'h321;
    waitFrameStart(FRAME + 10, n);
    runCycles(FRAME);

    $display("[TB] one-cycle reset mid-line");
    runTo(20, 15);
    clr_n = 1'b0;
    runCycles(1);
    clr_n = 1'b1;
    waitFrameStart(10, n);
    checkValue("midline_reset_latency", n, 2);
    checkFramePeriod("post_reset");
    runCycles(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
